// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter.
//   state_t : transaction FSM states (IDLE, ACCESS, WAIT, RESP)
//   owner_t : which requester owns the current/last transaction
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Grant decision between instruction fetch and data port, with the
// anti-starvation streak counter.
//   clk, rst_n : clock, async active-low reset
//   grant_en   : 1 when the arbiter can accept a new transaction
//   if_req     : fetch request
//   dm_req     : data request
//   grant      : a transaction is granted this cycle
//   winner     : requester granted (valid when grant=1)
module mem_arb_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   grant_en,
    input  logic   if_req,
    input  logic   dm_req,
    output logic   grant,
    output owner_t winner
);

    localparam int unsigned SW = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    logic [SW-1:0] streak_q;

    always_comb begin
        grant  = grant_en && (if_req || dm_req);
        winner = OWN_IF;
        // Data wins contention unless it has already taken the maximum streak.
        if (dm_req && !(if_req && (streak_q == STREAK_MAX)))
            winner = OWN_DM;
    end

    // Only contested data grants count; an uncontested data grant holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else if (grant) begin
            if (winner == OWN_IF)
                streak_q <= '0;
            else if (if_req && (streak_q != STREAK_MAX))
                streak_q <= streak_q + 1'b1;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and
// the data (memory-stage) port. One transaction every 4 cycles:
// IDLE (arbitrate/latch) -> ACCESS (address into RAM, store write)
// -> WAIT (capture RAM q) -> RESP (one-cycle ack).
//   if_req/if_addr/if_ack/if_rdata           : fetch port
//   dm_req/dm_we/dm_addr/dm_wdata/dm_ack/dm_rdata : data port
//   ram_addr/ram_wren/ram_wdata/ram_rdata    : RAM interface
//   owner                                    : 0 fetch, 1 data (current/last)
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W        = 11,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              owner
);

    state_t            state_q, state_d;
    owner_t            owner_q, winner;
    logic              grant;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    mem_arb_picker #(
        .MAX_DM_STREAK (MAX_DM_STREAK)
    ) u_picker (
        .clk      (clk),
        .rst_n    (rst_n),
        .grant_en (state_q == IDLE),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .grant    (grant),
        .winner   (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ram_wren = 1'b0;
        if_ack   = 1'b0;
        dm_ack   = 1'b0;
        unique case (state_q)
            IDLE:   if (grant) state_d = ACCESS;
            ACCESS: begin
                ram_wren = we_q;
                state_d  = WAIT;
            end
            WAIT:   state_d = RESP;
            RESP: begin
                if_ack  = (owner_q == OWN_IF);
                dm_ack  = (owner_q == OWN_DM);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // addr_q only changes at a grant, so driving it straight out gives the
    // latched address in ACCESS/WAIT and holds the last one elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (grant) begin
                owner_q <= winner;
                if (winner == OWN_DM) begin
                    addr_q  <= dm_addr;
                    we_q    <= dm_we;
                    wdata_q <= dm_wdata;
                end else begin
                    addr_q  <= if_addr;
                    we_q    <= 1'b0;
                end
            end
            if (state_q == WAIT)
                rdata_q <= ram_rdata;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign if_rdata  = rdata_q;
    assign dm_rdata  = rdata_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              owner;

    int cmp_count  = 0;
    int fail_count = 0;

    // RAM model: registered address, unregistered q; plus a bench preload port.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] addr_r;
    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (ram_wren)
            mem[ram_addr] <= ram_wdata;
        addr_r <= ram_addr;
    end
    assign ram_rdata = mem[addr_r];

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .MAX_DM_STREAK (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .ram_addr  (ram_addr),
        .ram_wren  (ram_wren),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .owner     (owner)
    );

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Advance negedges until an ack is seen (bounded); n = cycles waited.
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(if_ack || dm_ack) && n < 12);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
        dm_addr = '0; dm_wdata = '0;
        #12;
        cmp_count++;
        if ({if_ack, dm_ack, ram_wren, owner} !== 4'b0) begin
            fail_count++; $display("FAIL reset_ctrl: got %b want 0000", {if_ack, dm_ack, ram_wren, owner});
        end
        cmp_count++;
        if ({ram_addr, ram_wdata, if_rdata, dm_rdata} !== '0) begin
            fail_count++; $display("FAIL reset_data: got addr=%h wd=%h ird=%h drd=%h want 0",
                                   ram_addr, ram_wdata, if_rdata, dm_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_basic;
        int acks_dm = 0;
        preload(5, 32'hE3A00001);
        @(negedge clk);
        if_req = 1; if_addr = 5;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (dm_ack) acks_dm++;
            cmp_count++;
            if (if_ack !== (c == 3)) begin
                fail_count++; $display("FAIL fetch_latency: cycle %0d if_ack=%b want %b", c, if_ack, c == 3);
            end
        end
        cmp_count++;
        if (if_rdata !== 32'hE3A00001) begin
            fail_count++; $display("FAIL fetch_data: got %h want e3a00001", if_rdata);
        end
        if_req = 0;
        repeat (2) begin @(negedge clk); if (dm_ack) acks_dm++; end
        cmp_count++;
        if (acks_dm != 0) begin
            fail_count++; $display("FAIL fetch_no_dm_ack: got %0d dm_acks want 0", acks_dm);
        end
    endtask

    task automatic test_store_then_fetch;
        int wren_cycles = 0;
        int n;
        @(negedge clk);
        dm_req = 1; dm_we = 1; dm_addr = 10; dm_wdata = 32'hDEADBEEF;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (ram_wren) wren_cycles++;
            cmp_count++;
            if (dm_ack !== (c == 3)) begin
                fail_count++; $display("FAIL store_ack: cycle %0d dm_ack=%b want %b", c, dm_ack, c == 3);
            end
        end
        dm_req = 0; dm_we = 0;
        repeat (3) begin @(negedge clk); if (ram_wren) wren_cycles++; end
        cmp_count++;
        if (wren_cycles != 1) begin
            fail_count++; $display("FAIL store_wren_cycles: got %0d want 1", wren_cycles);
        end
        if_req = 1; if_addr = 10;
        wait_ack(n);
        cmp_count++;
        if (!(if_ack && !dm_ack && n == 3 && if_rdata === 32'hDEADBEEF)) begin
            fail_count++; $display("FAIL store_readback: if_ack=%b n=%0d data=%h want ack after 3, deadbeef",
                                   if_ack, n, if_rdata);
        end
        if_req = 0;
        @(negedge clk);
    endtask

    task automatic test_contention;
        int n;
        preload(3, 32'h33333333);
        preload(7, 32'h77777777);
        @(negedge clk);
        if_req = 1; if_addr = 7; dm_req = 1; dm_we = 0; dm_addr = 3;
        wait_ack(n);
        cmp_count++;
        if (!(dm_ack && !if_ack && n == 3 && dm_rdata === 32'h33333333 && owner === 1'b1)) begin
            fail_count++; $display("FAIL contention_dm: dm_ack=%b if_ack=%b n=%0d data=%h owner=%b want dm at 3, 33333333",
                                   dm_ack, if_ack, n, dm_rdata, owner);
        end
        dm_req = 0;
        wait_ack(n);
        cmp_count++;
        if (!(if_ack && !dm_ack && n == 4 && if_rdata === 32'h77777777 && owner === 1'b0)) begin
            fail_count++; $display("FAIL contention_if: if_ack=%b dm_ack=%b n=%0d(+3) data=%h owner=%b want if at cycle 7, 77777777",
                                   if_ack, dm_ack, n, if_rdata, owner);
        end
        if_req = 0;
        @(negedge clk);
    endtask

    task automatic test_streak;
        int n;
        logic want_dm;
        logic [DATA_W-1:0] want;
        for (int i = 100; i < 108; i++) preload(ADDR_W'(i), 32'hA0000000 | i);
        @(negedge clk);
        if_req = 1; if_addr = 5; dm_req = 1; dm_we = 0; dm_addr = 100;
        for (int t = 0; t < 10; t++) begin
            wait_ack(n);
            want_dm = ((t % 5) != 4);
            want = want_dm ? (32'hA0000000 | 32'(dm_addr)) : 32'hE3A00001;
            cmp_count++;
            if (!(dm_ack === want_dm && if_ack === !want_dm && if_rdata === want)) begin
                fail_count++; $display("FAIL streak_pattern: txn %0d dm_ack=%b if_ack=%b data=%h want dm=%b data=%h",
                                       t, dm_ack, if_ack, if_rdata, want_dm, want);
            end
            if (dm_ack) dm_addr = dm_addr + 1'b1;
        end
        if_req = 0; dm_req = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int acks = 0;
        preload(20, 32'h0BADF00D);
        @(negedge clk);
        dm_req = 1; dm_we = 1; dm_addr = 20; dm_wdata = 32'h12345678;
        @(negedge clk);
        cmp_count++;
        if (ram_wren !== 1'b1 || ram_addr !== 20) begin
            fail_count++; $display("FAIL rst_mid_access: wren=%b addr=%0d want 1, 20", ram_wren, ram_addr);
        end
        #1 rst_n = 1'b0;
        #1;
        dm_req = 0; dm_we = 0;
        cmp_count++;
        if ({if_ack, dm_ack, ram_wren, owner} !== 4'b0 || {ram_addr, ram_wdata, if_rdata, dm_rdata} !== '0) begin
            fail_count++; $display("FAIL rst_mid_outputs: ack=%b%b wren=%b owner=%b addr=%h wd=%h rd=%h want all 0",
                                   if_ack, dm_ack, ram_wren, owner, ram_addr, ram_wdata, if_rdata);
        end
        cmp_count++;
        if (dut.state_q !== IDLE) begin
            fail_count++; $display("FAIL rst_mid_state: got %0d want IDLE", dut.state_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); if (if_ack || dm_ack) acks++; end
        cmp_count++;
        if (acks != 0 || mem[20] !== 32'h0BADF00D) begin
            fail_count++; $display("FAIL rst_mid_discard: acks=%0d mem20=%h want 0, 0badf00d", acks, mem[20]);
        end
    endtask

    task automatic test_fetch_seq;
        int n;
        for (int i = 40; i < 44; i++) preload(ADDR_W'(i), 32'hC0DE0000 + i);
        @(negedge clk);
        if_req = 1; if_addr = 40;
        for (int k = 0; k < 4; k++) begin
            wait_ack(n);
            cmp_count++;
            if (!(if_ack && n == ((k == 0) ? 3 : 4) && if_rdata === 32'hC0DE0000 + 32'(40 + k))) begin
                fail_count++; $display("FAIL fetch_seq: word %0d ack=%b n=%0d data=%h want n=%0d data=%h",
                                       k, if_ack, n, if_rdata, (k == 0) ? 3 : 4, 32'hC0DE0000 + 32'(40 + k));
            end
            if_addr = if_addr + 1'b1;
        end
        if_req = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_fetch_basic;
        test_store_then_fetch;
        test_contention;
        test_streak;
        test_reset_mid;
        test_fetch_seq;
        $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, word-address width of the shared RAM.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MAX_DM_STREAK, default 4, maximum consecutive contested data-port grants before fetch is forced a grant.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 if_req  input  1  instruction-fetch request.
REQ-007 if_addr  input  ADDR_W  fetch word address.
REQ-008 if_ack  output  1  fetch completion pulse.
REQ-009 if_rdata  output  DATA_W  fetched word, valid while if_ack=1.
REQ-010 dm_req  input  1  memory-stage request.
REQ-011 dm_we  input  1  1 = store, 0 = load.
REQ-012 dm_addr  input  ADDR_W  data word address.
REQ-013 dm_wdata  input  DATA_W  store data.
REQ-014 dm_ack  output  1  data completion pulse.
REQ-015 dm_rdata  output  DATA_W  load data, valid while dm_ack=1; don't-care for stores.
REQ-016 ram_addr  output  ADDR_W  to single-port synchronous RAM (address registered inside RAM, unregistered q).
REQ-017 ram_wren  output  1  RAM write enable.
REQ-018 ram_wdata  output  DATA_W  RAM write data.
REQ-019 ram_rdata  input  DATA_W  RAM q; valid the cycle after ram_addr is sampled.
REQ-020 owner  output  1  0 = fetch, 1 = data; owner of the current or last transaction.

Function
REQ-021 FSM states IDLE, ACCESS, WAIT, RESP; IDLE->ACCESS when any req=1 at the edge; ACCESS->WAIT; WAIT->RESP; RESP->IDLE unconditionally.
REQ-022 In IDLE the winner's addr, we (0 for fetch), and wdata are latched, and owner is updated at the same edge.
REQ-023 Arbitration in IDLE: a single requester wins; when both request, data wins unless streak == MAX_DM_STREAK, in which case fetch wins.
REQ-024 streak increments (saturating at MAX_DM_STREAK) on each data grant made while if_req=1; it clears to 0 on every fetch grant and is otherwise held.
REQ-025 ram_addr drives the latched address in ACCESS and WAIT and holds its last value elsewhere; ram_wren=1 only in ACCESS and only if the latched we=1, exactly one cycle per store.
REQ-026 ram_wdata drives the latched wdata in all states.
REQ-027 In WAIT, ram_rdata is captured into a response register, which drives if_rdata and dm_rdata.
REQ-028 In RESP, exactly one of if_ack or dm_ack (selected by owner) is high for exactly one cycle; both are 0 in every other state.
REQ-029 Latency: req sampled at edge 0 produces ack high during cycle 3; throughput is one transaction per 4 cycles.
REQ-030 A requester holds req, addr, we, and wdata stable until its ack; a req still high in the ack cycle is treated as a new request in the following IDLE cycle.
REQ-031 Requests arriving outside IDLE are not sampled; the losing requester waits without loss.

Reset
REQ-032 rst_n=0 immediately forces IDLE, if_ack=dm_ack=0, ram_wren=0, ram_addr=0, ram_wdata=0, rdata registers=0, owner=0, streak=0.
REQ-033 Reset mid-transaction discards the transaction with no ack; a store reset before the ACCESS-cycle edge does not write RAM.

Structure
REQ-034 Shared package mem_arb_pkg holds the state enum (IDLE, ACCESS, WAIT, RESP) and the owner enum (OWN_IF, OWN_DM).
REQ-035 One sub-module, mem_arb_picker, holds the grant decision and the streak counter; the FSM and datapath registers reside in unified_mem_arbiter.

Verification
REQ-036 RAM[5]=0xE3A00001, if_req=1 with if_addr=5 -> if_ack in cycle 3 with if_rdata=0xE3A00001; dm_ack stays 0.
REQ-037 dm store 0xDEADBEEF to address 10, then fetch of address 10 -> ram_wren high for exactly 1 cycle; if_rdata=0xDEADBEEF.
REQ-038 if_req and dm_req (load, address 3) rise together -> dm_ack in cycle 3, if_ack in cycle 7.
REQ-039 dm_req and if_req both held continuously (dm address incremented on each ack) -> 4 dm_acks, then 1 if_ack, then the pattern repeats.
REQ-040 rst_n pulsed low during ACCESS of a store of 0x12345678 to address 20 -> RAM[20] unchanged, no ack, FSM in IDLE, all outputs at reset values.
REQ-041 Fetch-only, if_addr incremented on each ack for 4 words -> if_acks every 4 cycles with the correct sequential data.
